// File: rtl/mips_boot_loader.sv
// mips_boot_loader: streams a program image into memory, verifies it, then hands the bus to the CPU
module mips_boot_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int BASE   = 0,
  parameter int VERIFY = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [ADDR_W:0]   LEN,
  input  logic              LD_VALID,
  input  logic [DATA_W-1:0] LD_DATA,
  output logic              LD_READY,
  output logic              INIT,
  output logic              CS_L,
  output logic              WE_L,
  output logic [ADDR_W-1:0] ADDR_L,
  inout  wire  [DATA_W-1:0] MEM_BUS,
  output logic              CPU_RST,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W-1:0] ERR_ADDR
);
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LOAD    = 4'd1;
  localparam logic [3:0] S_WRITE   = 4'd2;
  localparam logic [3:0] S_READ    = 4'd3;
  localparam logic [3:0] S_CMP     = 4'd4;
  localparam logic [3:0] S_ADV     = 4'd5;
  localparam logic [3:0] S_RELEASE = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERROR   = 4'd8;
  localparam logic [ADDR_W:0]   CAP    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  logic [3:0]        state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              start_ok, match, adv, last;

  // Every port output is a pure decode of the state, so an async reset takes effect at once
  assign LD_READY = state_q == S_LOAD;
  assign INIT     = state_q inside {S_LOAD, S_WRITE, S_READ, S_CMP, S_ADV};
  assign CS_L     = state_q inside {S_WRITE, S_READ, S_CMP};
  assign WE_L     = state_q == S_WRITE;
  assign MEM_BUS  = WE_L ? data_q : 'z;
  assign CPU_RST  = state_q != S_DONE;
  assign DONE     = state_q == S_DONE;
  assign ERR      = state_q == S_ERROR;
  assign ADDR_L   = addr_q;
  assign ERR_ADDR = err_addr_q;

  assign start_ok = START && (state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign match    = MEM_BUS == data_q;
  // A matching compare advances directly, giving 4 cycles per verified word
  assign adv      = state_q == S_ADV || (state_q == S_CMP && match);
  assign last     = (cnt_q + (ADDR_W+1)'(1)) == n_q;

  // Next-state and datapath: load sequencing, readback check, address advance
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_addr_d = err_addr_q;
    if (start_ok) begin
      n_d     = LEN > CAP ? CAP : LEN;
      cnt_d   = '0;
      addr_d  = BASE_A;
      state_d = LEN == '0 ? S_RELEASE : S_LOAD;
    end else if (state_q == S_LOAD && LD_VALID) begin
      data_d  = LD_DATA;
      state_d = S_WRITE;
    end else if (state_q == S_WRITE) begin
      state_d = VERIFY != 0 ? S_READ : S_ADV;
    end else if (state_q == S_READ) begin
      state_d = S_CMP;
    end else if (state_q == S_CMP && !match) begin
      err_addr_d = addr_q;
      state_d    = S_ERROR;
    end else if (adv) begin
      cnt_d   = cnt_q + (ADDR_W+1)'(1);
      addr_d  = last ? addr_q : addr_q + ADDR_W'(1);
      state_d = last ? S_RELEASE : S_LOAD;
    end else if (state_q == S_RELEASE) begin
      state_d = S_DONE;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      cnt_q      <= '0;
      addr_q     <= BASE_A;
      data_q     <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_addr_q <= err_addr_d;
    end
  end
endmodule

// File: tb/tb_mips_boot_loader.sv
// tb_mips_boot_loader: directed checks of the boot loader against a small synchronous memory model
module tb_mips_boot_loader;
  localparam int AW = 7;
  localparam int DW = 32;

  logic          CLK = 0, RST_N = 0, START = 0, LD_VALID = 0;
  logic [AW:0]   LEN = '0;
  logic [DW-1:0] LD_DATA = '0;
  logic          LD_READY, INIT, CS_L, WE_L, CPU_RST, DONE, ERR;
  logic [AW-1:0] ADDR_L, ERR_ADDR;
  wire  [DW-1:0] MEM_BUS;

  logic [DW-1:0] mem [0:127];
  logic [DW-1:0] rd_q = '0;
  logic [127:0]  written = '0;
  logic          corrupt = 0, probe_en = 0, clr = 0;
  int            wr_cnt = 0, cs_cyc = 0, viol = 0, first_wr = 0, last_wr = 0;
  int            cyc = 0, t0 = 0, fed = 0, t_init = 0, t_rst = 0;
  int            checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  mips_boot_loader dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .LEN(LEN), .LD_VALID(LD_VALID),
    .LD_DATA(LD_DATA), .LD_READY(LD_READY), .INIT(INIT), .CS_L(CS_L), .WE_L(WE_L),
    .ADDR_L(ADDR_L), .MEM_BUS(MEM_BUS), .CPU_RST(CPU_RST), .DONE(DONE), .ERR(ERR),
    .ERR_ADDR(ERR_ADDR)
  );

  // Memory drives the bus while read-selected; the probe pulls it to zero so an undriven bus reads 0
  assign MEM_BUS = (CS_L && !WE_L) ? rd_q : (probe_en ? '0 : 'z);

  // Synchronous memory with optional corruption of address 3, plus bus activity bookkeeping
  always @(posedge CLK) begin
    if (clr) begin
      written <= '0;
      wr_cnt  <= 0;
      cs_cyc  <= 0;
    end else begin
      if (CS_L && WE_L) begin
        mem[ADDR_L]     <= MEM_BUS;
        written[ADDR_L] <= 1'b1;
        wr_cnt          <= wr_cnt + 1;
        last_wr         <= int'(ADDR_L);
        if (wr_cnt == 0) first_wr <= int'(ADDR_L);
      end
      if (CS_L) cs_cyc <= cs_cyc + 1;
    end
    if (CS_L && !WE_L) rd_q <= mem[ADDR_L] ^ {31'b0, corrupt && ADDR_L == 7'd3};
    if (!INIT && (CS_L || WE_L)) viol <= viol + 1;
  end

  function automatic logic [31:0] img(input int k);
    return 32'h2001_0006 + k;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic clear();
    clr = 1;
    tick();
    clr = 0;
  endtask

  task automatic pulse_start(input int len);
    LEN   = len[AW:0];
    START = 1;
    tick();
    START = 0;
    t0    = cyc;
  endtask

  task automatic probe_bus(input string tag);
    probe_en = 1;
    #1;
    check(tag, MEM_BUS, 32'h0);
    probe_en = 0;
  endtask

  // Offers words [from,to) with an optional idle gap after each accepted word
  task automatic run_load(input int from, input int to, input int gap, input int budget);
    int  c;
    logic fire;
    fed = from;
    c   = 0;
    while (fed < to && c < budget && !ERR && !DONE) begin
      LD_VALID = 1;
      LD_DATA  = img(fed);
      fire     = LD_READY;
      tick();
      c++;
      if (fire) begin
        fed++;
        if (gap > 0) begin
          LD_VALID = 0;
          repeat (gap) tick();
          c += gap;
          if (gap >= 4 && fed < to) check("stall_ready", LD_READY, 1);
        end
      end
    end
    LD_VALID = 0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c      = 0;
    t_init = -1;
    t_rst  = -1;
    while (!DONE && !ERR && c < budget) begin
      tick();
      c++;
      if (!INIT && t_init < 0) t_init = cyc;
      if (!CPU_RST && t_rst < 0) t_rst = cyc;
    end
    check("done_in_budget", DONE, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    clr = 1;
    tick();
    tick();
    check("rst_init", INIT, 0);
    check("rst_cs", CS_L, 0);
    check("rst_we", WE_L, 0);
    check("rst_addr", ADDR_L, 0);
    check("rst_ready", LD_READY, 0);
    check("rst_cpu_rst", CPU_RST, 1);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    check("rst_err_addr", ERR_ADDR, 0);
    probe_bus("rst_bus_z");
    RST_N = 1;
    clr   = 0;
    tick();

    // Back-to-back load of 10 words
    clear();
    pulse_start(10);
    check("t1_ready", LD_READY, 1);
    check("t1_init", INIT, 1);
    run_load(0, 10, 0, 200);
    check("t1_fed", fed, 10);
    wait_done(50);
    check("t1_latency", cyc - t0, 41);
    check("t1_rst_after_init", t_rst - t_init, 1);
    check("t1_wr_cnt", wr_cnt, 10);
    check("t1_first", first_wr, 0);
    check("t1_last", last_wr, 9);
    check("t1_mem0", mem[0], img(0));
    check("t1_mem9", mem[9], img(9));
    check("t1_cpu_rst", CPU_RST, 0);
    check("t1_init_off", INIT, 0);
    probe_bus("t1_bus_z");

    // Stalled source, 5 idle cycles between words
    clear();
    pulse_start(6);
    check("t2_cpu_rst", CPU_RST, 1);
    run_load(0, 6, 5, 300);
    check("t2_fed", fed, 6);
    wait_done(50);
    check("t2_wr_cnt", wr_cnt, 6);
    check("t2_cs_cycles", cs_cyc, 18);
    for (int k = 0; k < 6; k++) check("t2_mem", mem[k], img(k));

    // Corrupted readback at address 3
    clear();
    corrupt = 1;
    pulse_start(8);
    run_load(0, 8, 0, 100);
    repeat (3) tick();
    check("t3_err", ERR, 1);
    check("t3_err_addr", ERR_ADDR, 3);
    check("t3_cpu_rst", CPU_RST, 1);
    check("t3_init", INIT, 0);
    check("t3_done", DONE, 0);
    check("t3_no_wr4", written[4], 0);
    check("t3_wr_cnt", wr_cnt, 4);
    check("t3_fed", fed, 4);
    corrupt = 0;
    clear();
    pulse_start(8);
    check("t3_err_cleared", ERR, 0);
    run_load(0, 8, 0, 100);
    wait_done(50);
    check("t3_reload_err", ERR, 0);
    check("t3_reload_wr", wr_cnt, 8);

    // Zero length and oversize length
    clear();
    pulse_start(0);
    check("t4_zero_done_early", DONE, 0);
    check("t4_zero_init", INIT, 0);
    check("t4_zero_cpu_rst", CPU_RST, 1);
    tick();
    check("t4_zero_done", DONE, 1);
    check("t4_zero_cpu_run", CPU_RST, 0);
    check("t4_zero_cs", cs_cyc, 0);
    clear();
    pulse_start(200);
    run_load(0, 200, 0, 1000);
    check("t4_fed", fed, 128);
    wait_done(20);
    check("t4_wr_cnt", wr_cnt, 128);
    check("t4_first", first_wr, 0);
    check("t4_last", last_wr, 127);
    check("t4_addr", ADDR_L, 127);
    check("t4_mem127", mem[127], img(127));

    // Asynchronous reset during the write of word 5
    clear();
    pulse_start(10);
    run_load(0, 6, 0, 100);
    check("t5_pre_cs", CS_L, 1);
    check("t5_pre_we", WE_L, 1);
    RST_N = 0;
    #1;
    check("t5_cs", CS_L, 0);
    check("t5_we", WE_L, 0);
    check("t5_cpu_rst", CPU_RST, 1);
    check("t5_init", INIT, 0);
    check("t5_ready", LD_READY, 0);
    check("t5_addr", ADDR_L, 0);
    probe_bus("t5_bus_z");
    tick();
    check("t5_wr_cnt", wr_cnt, 5);
    RST_N = 1;
    tick();
    clear();
    pulse_start(4);
    run_load(0, 4, 0, 100);
    wait_done(50);
    check("t5_first", first_wr, 0);
    check("t5_wr_cnt2", wr_cnt, 4);

    // START pulsed mid-load must be ignored
    clear();
    pulse_start(5);
    run_load(0, 2, 0, 50);
    LEN   = 8'd1;
    START = 1;
    tick();
    START = 0;
    run_load(2, 5, 0, 100);
    check("t6_fed", fed, 5);
    wait_done(50);
    check("t6_wr_cnt", wr_cnt, 5);
    check("t6_first", first_wr, 0);
    check("t6_addr", ADDR_L, 4);
    check("t6_mem4", mem[4], img(4));

    check("bus_idle_when_cpu_owns", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
